shift_exec: RTL and testbench
=============================

SHIFT_EXEC -- requirements
Module: shift_exec

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter TAG_W, default 5, destination-register tag width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous pipeline kill; discards all in-flight ops.
REQ-006 in_valid  input  1  upstream offers an operation.
REQ-007 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-008 in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-009 in_src  input  XLEN  operand to shift.
REQ-010 in_amt  input  log2(XLEN)  shift amount; upper bits of a wider source are dropped by upstream.
REQ-011 in_tag  input  TAG_W  destination tag, carried unchanged.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-014 out_result  output  XLEN  shifted value.
REQ-015 out_tag  output  TAG_W  tag of out_result.
REQ-016 busy  output  1  high when any stage holds a valid op.

Function
REQ-017 Two registered stages: S1 (operand capture), S2 (result register); latency exactly 2 cycles from accept to out_valid with out_ready held high.
REQ-018 Throughput one op/cycle when out_ready stays high.
REQ-019 S2 advances when !s2_valid || out_ready; S1 advances into S2 under the same condition.
REQ-020 in_ready = !flush && (!s1_valid || s2_can_load); combinational, no dependency on in_valid.
REQ-021 SLL: src << amt, zero fill; SRL: src >> amt, zero fill; SRA: sign fill from src[XLEN-1]; ROL: bits shifted out of MSB re-enter at LSB.
REQ-022 amt = 0 yields out_result = src for all ops.
REQ-023 Result computed combinationally from S1 registers and captured into S2; out_result/out_tag are S2 registers, no combinational path from in_* to out_*.
REQ-024 While out_valid && !out_ready, out_result, out_tag, out_valid hold stable.
REQ-025 flush clears s1_valid and s2_valid next edge; flush wins over simultaneous in_valid (no accept) and over simultaneous output handshake (output still counts as consumed that cycle).
REQ-026 Data registers not cleared by flush/reset; only valid bits are.
REQ-027 busy = s1_valid || s2_valid.

Reset
REQ-028 rst high at an edge: s1_valid=0, s2_valid=0, so out_valid=0, busy=0, in_ready=1 on the following cycle.
REQ-029 rst mid-operation drops all in-flight ops with no output transfer; rst has priority over flush and in_valid.
REQ-030 out_result and out_tag are don't-care while out_valid=0.

Configuration
REQ-031 Macro SHIFT_EXEC_ZERO_FLAG_EN defined: extra output out_zero (1 bit), registered in S2, high when the captured result equals 0, held with out_result, reset 0.
REQ-032 Macro undefined: port out_zero and its register absent; all other behaviour identical.

Structure
REQ-033 Shared package shift_pkg holds op encoding constants (SHIFT_OP_SLL/SRL/SRA/ROL) and the op typedef, reused by decode.
REQ-034 One sub-module shift_core: combinational, inputs src/amt/op, output result; shift_exec holds all handshake and pipeline state.

Verification
REQ-035 Reset then single op SLL src=0x0000_0001 amt=31, tag=3, out_ready=1 -> out_valid exactly 2 cycles after accept, result 0x8000_0000, tag 3.
REQ-036 Back-to-back SRA 0x8000_0000 amt 4, SRL 0x8000_0000 amt 4, ROL 0x8000_0001 amt 1 -> results 0xF800_0000, 0x0800_0000, 0x0000_0003 on consecutive cycles, in order.
REQ-037 out_ready low 5 cycles with 3 ops offered -> exactly 2 accepted, in_ready low, outputs stable; release -> ops delivered in order, none lost/duplicated.
REQ-038 amt=0 for each op with src=0xDEAD_BEEF -> result 0xDEAD_BEEF.
REQ-039 flush asserted with both stages full and in_valid=1 -> next cycle out_valid=0, busy=0, no accept that cycle; subsequent op completes normally.
REQ-040 rst asserted while out_valid && !out_ready -> out_valid=0 next cycle; with SHIFT_EXEC_ZERO_FLAG_EN, SRL 0x0000_0001 amt 1 -> out_zero=1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift execution unit: operation encoding.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_OP_SLL = 2'b00,
        SHIFT_OP_SRL = 2'b01,
        SHIFT_OP_SRA = 2'b10,
        SHIFT_OP_ROL = 2'b11
    } shift_op_e;

endpackage : shift_pkg

// File: rtl/shift_core.sv
// Combinational shifter: logical left/right, arithmetic right, rotate left.
module shift_core
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int AW  = $clog2(XLEN)
) (
    input  logic [XLEN-1:0] src,
    input  logic [AW-1:0]   amt,
    input  shift_op_e       op,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] rot_wide;

    // Rotate is taken from the upper half of the doubled operand shifted left,
    // which also gives src back unchanged when amt is zero.
    always_comb begin
        rot_wide = {src, src} << amt;
        result   = src;
        unique case (op)
            SHIFT_OP_SLL: result = src << amt;
            SHIFT_OP_SRL: result = src >> amt;
            SHIFT_OP_SRA: result = $signed(src) >>> amt;
            SHIFT_OP_ROL: result = rot_wide[2*XLEN-1:XLEN];
            default:      result = src;
        endcase
    end

endmodule : shift_core

// File: rtl/shift_exec.sv
// Two-stage shift execution unit with valid/ready handshake on both sides.
// S1 captures the operands, S2 holds the registered result.
// Optional macro SHIFT_EXEC_ZERO_FLAG_EN adds the registered out_zero output.
module shift_exec
    import shift_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    localparam int AW   = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_src,
    input  logic [AW-1:0]    in_amt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
`ifdef SHIFT_EXEC_ZERO_FLAG_EN
    output logic             out_zero,
`endif
    output logic             busy
);

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    shift_op_e        s1_op_q;
    logic [XLEN-1:0]  s1_src_q;
    logic [AW-1:0]    s1_amt_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [XLEN-1:0]  s2_result_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [XLEN-1:0]  core_result;
    logic             s2_can_load;
    logic             accept;
    logic             s2_load;

    assign s2_can_load = !s2_valid_q || out_ready;
    assign in_ready    = !flush && (!s1_valid_q || s2_can_load);
    assign accept      = in_valid && in_ready;
    assign s2_load     = s2_can_load && s1_valid_q;

    shift_core #(.XLEN(XLEN)) u_core (
        .src    (s1_src_q),
        .amt    (s1_amt_q),
        .op     (s1_op_q),
        .result (core_result)
    );

    // Next-state of the stage valid bits; flush kills both stages.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_can_load) begin
                s2_valid_d = s1_valid_q;
            end
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (s2_can_load) begin
                s1_valid_d = 1'b0;
            end
        end
    end

    // Valid bits are the only pipeline state touched by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Operand capture and result register; S2 only reloads from a valid S1,
    // so a stalled result stays put.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op_q  <= shift_op_e'(in_op);
            s1_src_q <= in_src;
            s1_amt_q <= in_amt;
            s1_tag_q <= in_tag;
        end
        if (s2_load) begin
            s2_result_q <= core_result;
            s2_tag_q    <= s1_tag_q;
        end
    end

`ifdef SHIFT_EXEC_ZERO_FLAG_EN
    logic s2_zero_q;

    // Zero flag follows the result register and clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_zero_q <= 1'b0;
        end else if (s2_load) begin
            s2_zero_q <= (core_result == '0);
        end
    end

    assign out_zero = s2_zero_q;
`endif

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_tag    = s2_tag_q;
    assign busy       = s1_valid_q || s2_valid_q;

endmodule : shift_exec

// File: tb/tb_shift_exec.sv
// Directed bench for shift_exec; inputs driven and outputs sampled on the falling edge.
module tb_shift_exec;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0]  in_op;
    logic [31:0] in_src, out_result;
    logic [4:0]  in_amt, in_tag, out_tag;
`ifdef SHIFT_EXEC_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  v_op  [4];
    logic [31:0] v_src [4];
    logic [4:0]  v_amt [4];
    logic [4:0]  v_tag [4];
    logic [31:0] v_exp [4];

    always #5 clk = ~clk;

    shift_exec #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src     (in_src),
        .in_amt     (in_amt),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
`ifdef SHIFT_EXEC_ZERO_FLAG_EN
        .out_zero   (out_zero),
`endif
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] src,
                         input logic [4:0] amt, input logic [4:0] tag);
        in_valid = v;
        in_op    = op;
        in_src   = src;
        in_amt   = amt;
        in_tag   = tag;
    endtask

    task automatic set_vec(input int i, input logic [1:0] op, input logic [31:0] src,
                           input logic [4:0] amt, input logic [4:0] tag, input logic [31:0] exp);
        v_op[i]  = op;
        v_src[i] = src;
        v_amt[i] = amt;
        v_tag[i] = tag;
        v_exp[i] = exp;
    endtask

    // Issue n vectors back to back into an empty pipe with out_ready high and
    // expect results two cycles after each accept, in order.
    task automatic stream(input int n, input string name);
        out_ready = 1'b1;
        for (int i = 0; i <= n + 1; i++) begin
            @(negedge clk);
            if (i < n) begin
                drive(1'b1, v_op[i], v_src[i], v_amt[i], v_tag[i]);
                #1;
                check_val({name, "_in_ready"}, 32'(in_ready), 32'd1);
            end else begin
                drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
                #1;
            end
            if (i < 2) begin
                check_val({name, "_lat_no_valid"}, 32'(out_valid), 32'd0);
            end else begin
                check_val({name, "_valid"}, 32'(out_valid), 32'd1);
                check_val({name, "_result"}, out_result, v_exp[i-2]);
                check_val({name, "_tag"}, 32'(out_tag), 32'(v_tag[i-2]));
`ifdef SHIFT_EXEC_ZERO_FLAG_EN
                check_val({name, "_zero"}, 32'(out_zero), 32'(v_exp[i-2] == 32'd0));
`endif
            end
        end
        @(negedge clk);
        #1;
        check_val({name, "_drained"}, 32'(out_valid), 32'd0);
        check_val({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("reset_out_valid", 32'(out_valid), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_in_ready", 32'(in_ready), 32'd1);

        // Single SLL, latency
        set_vec(0, 2'b00, 32'h0000_0001, 5'd31, 5'd3, 32'h8000_0000);
        stream(1, "sll31");

        // Back-to-back SRA / SRL / ROL
        set_vec(0, 2'b10, 32'h8000_0000, 5'd4, 5'd1, 32'hF800_0000);
        set_vec(1, 2'b01, 32'h8000_0000, 5'd4, 5'd2, 32'h0800_0000);
        set_vec(2, 2'b11, 32'h8000_0001, 5'd1, 5'd4, 32'h0000_0003);
        stream(3, "b2b");

        // amt = 0 for every op
        for (int k = 0; k < 4; k++)
            set_vec(k, 2'(k), 32'hDEAD_BEEF, 5'd0, 5'(k + 20), 32'hDEAD_BEEF);
        stream(4, "amt0");

        // Backpressure: three ops offered with out_ready low for 5 cycles
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd4, 5'd10);
        #1;
        check_val("bp_accept_a", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(1'b1, 2'b01, 32'h0000_00F0, 5'd4, 5'd11);
        #1;
        check_val("bp_accept_b", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(1'b1, 2'b11, 32'h8000_0000, 5'd4, 5'd12);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check_val("bp_in_ready_low", 32'(in_ready), 32'd0);
            check_val("bp_hold_valid", 32'(out_valid), 32'd1);
            check_val("bp_hold_result", out_result, 32'h0000_0010);
            check_val("bp_hold_tag", 32'(out_tag), 32'd10);
            check_val("bp_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_val("bp_rel_a_result", out_result, 32'h0000_0010);
        check_val("bp_rel_a_tag", 32'(out_tag), 32'd10);
        check_val("bp_accept_c", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
        #1;
        check_val("bp_rel_b_valid", 32'(out_valid), 32'd1);
        check_val("bp_rel_b_result", out_result, 32'h0000_000F);
        check_val("bp_rel_b_tag", 32'(out_tag), 32'd11);
        @(negedge clk);
        #1;
        check_val("bp_rel_c_valid", 32'(out_valid), 32'd1);
        check_val("bp_rel_c_result", out_result, 32'h0000_0008);
        check_val("bp_rel_c_tag", 32'(out_tag), 32'd12);
        @(negedge clk);
        #1;
        check_val("bp_no_dup", 32'(out_valid), 32'd0);

        // Flush with both stages full, in_valid high, output handshake active
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h0000_0003, 5'd1, 5'd5);
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h0000_0003, 5'd2, 5'd6);
        @(negedge clk);
        #1;
        check_val("fl_full_busy", 32'(busy), 32'd1);
        check_val("fl_full_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd1, 5'd9);
        #1;
        check_val("fl_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
        #1;
        check_val("fl_out_valid", 32'(out_valid), 32'd0);
        check_val("fl_busy", 32'(busy), 32'd0);
        set_vec(0, 2'b10, 32'hF000_0000, 5'd8, 5'd7, 32'hFFF0_0000);
        stream(1, "post_flush");

        // Reset while a result is stalled
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd1, 5'd8);
        @(negedge clk);
        drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clk);
        #1;
        check_val("rst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        flush = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd1, 5'd8);
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
        #1;
        check_val("rst_mid_valid", 32'(out_valid), 32'd0);
        check_val("rst_mid_busy", 32'(busy), 32'd0);
        check_val("rst_mid_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFT_EXEC_ZERO_FLAG_EN
        check_val("rst_zero", 32'(out_zero), 32'd0);
`endif

        // Zero result (exercises out_zero when present)
        set_vec(0, 2'b01, 32'h0000_0001, 5'd1, 5'd2, 32'h0000_0000);
        set_vec(1, 2'b00, 32'h0000_0001, 5'd0, 5'd3, 32'h0000_0001);
        stream(2, "zero");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_exec
